mf_pll_reset_ctrl: RTL and testbench

Reset sequencer and lock monitor for the `mf_pllbase` clock generator, running on the PLL's 74.25 MHz reference clock. It drives the PLL `rst` input and consumes the PLL `locked` output. It holds downstream logic (pixel, Uxn CPU / draw queue, VRAM domains) in reset until lock has been continuously stable. On lock loss or lock timeout it re-resets the PLL, and it reports status for debug.

---
 rtl/mf_pll_reset_ctrl.sv | 124 ++++++++++++
 tb/tb_mf_pll_reset_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mf_pll_reset_ctrl.sv
// rtl/mf_pll_reset_ctrl.sv - PLL reset sequencer and lock monitor
//
// Sequences the mf_pllbase reset, waits for lock, requires lock to stay
// continuously stable before releasing downstream reset, and re-resets the
// PLL on lock loss or lock timeout.
//
// Ports:
//   refclk        in   PLL reference clock, sole clock of this block
//   rst           in   synchronous active-high reset
//   pll_locked    in   raw PLL locked (asynchronous, synchronized here)
//   pll_rst       out  PLL reset, registered
//   sys_rst       out  downstream active-high reset, registered
//   lock_ok       out  high only while running with stable lock
//   relock_count  out  count of lock-loss events in run, saturates at 255
//   timeout_err   out  sticky lock-timeout flag, cleared only by rst

module mf_pll_reset_ctrl #(
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT       = 74250,
    parameter int LOCK_STABLE_CYCLES = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       lock_ok,
    output logic [7:0] relock_count,
    output logic       timeout_err
);

    localparam int MAX_AB = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [7:0]    relock_nxt;
    logic          timeout_nxt;
    logic          lk_m;
    logic          lk_s;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        relock_nxt  = relock_count;
        timeout_nxt = timeout_err;
        case (state)
            ST_RESET: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock seen on the last window cycle still counts as lock.
                if (lk_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt   = ST_RESET;
                    timeout_nxt = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lk_s) begin
                    state_nxt = ST_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                // Counter is unused in RUN; hold it so it cannot wrap.
                cnt_nxt = cnt;
                if (!lk_s) begin
                    state_nxt = ST_RESET;
                    if (relock_count != 8'hff) begin
                        relock_nxt = relock_count + 8'd1;
                    end
                end
            end
        endcase
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
    end

    // Outputs decode the next state so they move with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lk_m         <= 1'b0;
            lk_s         <= 1'b0;
            state        <= ST_RESET;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            lock_ok      <= 1'b0;
            relock_count <= 8'd0;
            timeout_err  <= 1'b0;
        end else begin
            lk_m         <= pll_locked;
            lk_s         <= lk_m;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            pll_rst      <= (state_nxt == ST_RESET);
            sys_rst      <= (state_nxt != ST_RUN);
            lock_ok      <= (state_nxt == ST_RUN);
            relock_count <= relock_nxt;
            timeout_err  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_mf_pll_reset_ctrl.sv
// tb/tb_mf_pll_reset_ctrl.sv - directed self-checking bench for mf_pll_reset_ctrl

module tb_mf_pll_reset_ctrl;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       lock_ok;
    logic [7:0] relock_count;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    mf_pll_reset_ctrl #(
        .RST_HOLD_CYCLES   (4),
        .LOCK_TIMEOUT      (50),
        .LOCK_STABLE_CYCLES(8)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .lock_ok     (lock_ok),
        .relock_count(relock_count),
        .timeout_err (timeout_err)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
        chk({tag, "_lock_ok"}, 32'(lock_ok), 32'd0);
        chk({tag, "_relock"}, 32'(relock_count), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    endtask

    // Bounded wait for downstream reset release.
    task automatic wait_release(input string tag, input int limit);
        int n;
        n = 0;
        while (sys_rst !== 1'b0 && n < limit) begin
            tick(1);
            n++;
        end
        chk({tag, "_release"}, 32'(sys_rst), 32'd0);
    endtask

    initial begin
        // Reset state
        tick(3);
        chk_reset_vals("por");

        // Normal bring-up
        rst = 1'b0;
        tick(3);
        chk("hold_last", 32'(pll_rst), 32'd1);
        tick(1);
        chk("hold_done", 32'(pll_rst), 32'd0);
        tick(6);
        pll_locked = 1'b1;
        tick(10);
        chk("pre_release", 32'(sys_rst), 32'd1);
        tick(1);
        chk("release", 32'(sys_rst), 32'd0);
        chk("run_lock_ok", 32'(lock_ok), 32'd1);
        chk("run_relock", 32'(relock_count), 32'd0);
        chk("run_timeout", 32'(timeout_err), 32'd0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        tick(2);
        chk("loss_early_sys", 32'(sys_rst), 32'd0);
        chk("loss_early_ok", 32'(lock_ok), 32'd1);
        tick(1);
        chk("loss_sys", 32'(sys_rst), 32'd1);
        chk("loss_pll", 32'(pll_rst), 32'd1);
        chk("loss_ok", 32'(lock_ok), 32'd0);
        chk("loss_relock", 32'(relock_count), 32'd1);
        pll_locked = 1'b1;
        tick(12);
        chk("relock_pre", 32'(sys_rst), 32'd1);
        tick(1);
        chk("relock_run", 32'(sys_rst), 32'd0);

        // Repeated losses up to saturation
        for (int k = 2; k <= 260; k++) begin
            pll_locked = 1'b0;
            tick(3);
            chk("sat_sys", 32'(sys_rst), 32'd1);
            chk("sat_count", 32'(relock_count), (k > 255) ? 32'd255 : 32'(k));
            pll_locked = 1'b1;
            wait_release("sat", 40);
        end

        // Mid-operation reset in RUN
        rst = 1'b1;
        pll_locked = 1'b0;
        tick(1);
        chk_reset_vals("rst_run");

        // Timeout with lock held low
        rst = 1'b0;
        tick(53);
        chk("to_before", 32'(timeout_err), 32'd0);
        chk("to_before_pll", 32'(pll_rst), 32'd0);
        tick(1);
        chk("to_set", 32'(timeout_err), 32'd1);
        chk("to_pll", 32'(pll_rst), 32'd1);
        tick(3);
        chk("to_hold", 32'(pll_rst), 32'd1);
        tick(1);
        chk("to_hold_done", 32'(pll_rst), 32'd0);
        tick(49);
        chk("to2_before", 32'(pll_rst), 32'd0);
        tick(1);
        chk("to2_pll", 32'(pll_rst), 32'd1);
        pll_locked = 1'b1;
        tick(12);
        chk("to_late_pre", 32'(sys_rst), 32'd1);
        tick(1);
        chk("to_late_run", 32'(sys_rst), 32'd0);
        chk("to_late_ok", 32'(lock_ok), 32'd1);
        chk("to_sticky", 32'(timeout_err), 32'd1);

        // Reset clears timeout, then reset again while in STABLE
        rst = 1'b1;
        tick(1);
        chk_reset_vals("rst_run2");
        rst = 1'b0;
        tick(5);
        chk("stable_sys", 32'(sys_rst), 32'd1);
        chk("stable_pll", 32'(pll_rst), 32'd0);
        rst = 1'b1;
        tick(1);
        chk_reset_vals("rst_stable");

        // Glitch 5 cycles into STABLE
        rst = 1'b0;
        tick(9);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        chk("gl_pll", 32'(pll_rst), 32'd0);
        chk("gl_sys", 32'(sys_rst), 32'd1);
        tick(1);
        chk("gl_no_early", 32'(sys_rst), 32'd1);
        tick(7);
        chk("gl_pre", 32'(sys_rst), 32'd1);
        tick(1);
        chk("gl_release", 32'(sys_rst), 32'd0);
        chk("gl_ok", 32'(lock_ok), 32'd1);

        // Boundary: lock seen on the last timeout-window cycle
        rst = 1'b1;
        pll_locked = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(51);
        pll_locked = 1'b1;
        tick(3);
        chk("bd_pll", 32'(pll_rst), 32'd0);
        chk("bd_timeout", 32'(timeout_err), 32'd0);
        tick(7);
        chk("bd_pre", 32'(sys_rst), 32'd1);
        tick(1);
        chk("bd_release", 32'(sys_rst), 32'd0);
        chk("bd_timeout_run", 32'(timeout_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
